// File: rtl/xor_fold_pipe_if.sv
// Handshake bundle for xor_fold_pipe: input beat stream and folded output stream.
// Optional parity output present only when XOR_FOLD_PARITY_EN is defined.
interface xor_fold_pipe_if #(
    parameter int DW   = 32,
    parameter int FOLD = 2,
    parameter int NCH  = 2
);
    localparam int OW = DW / FOLD;

    logic                mode;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [NCH*DW-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NCH*OW-1:0]   out_data;
    logic [7:0]          out_cnt;
`ifdef XOR_FOLD_PARITY_EN
    logic [NCH-1:0]      out_par;
`endif

    modport master (
        output mode, in_valid, in_last, in_data, out_ready,
`ifdef XOR_FOLD_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  mode, in_valid, in_last, in_data, out_ready,
`ifdef XOR_FOLD_PARITY_EN
        output out_par,
`endif
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/xor_fold_pipe.sv
// Multi-channel XOR word folder with per-beat or per-packet accumulation and a
// single output register. Macro XOR_FOLD_PARITY_EN adds per-channel output parity.
module xor_fold_pipe #(
    parameter int DW   = 32,
    parameter int FOLD = 2,
    parameter int NCH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    xor_fold_pipe_if.slave     bus
);
    localparam int OW = DW / FOLD;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    function automatic logic [OW-1:0] fold_word(input logic [DW-1:0] w);
        logic [OW-1:0] acc;
        acc = '0;
        for (int k = 0; k < FOLD; k++) begin
            acc = acc ^ w[k*OW +: OW];
        end
        return acc;
    endfunction

    function automatic logic parity_word(input logic [OW-1:0] w);
        return ^w;
    endfunction

    state_t              r_state;
    logic [NCH*OW-1:0]   r_acc;
    logic [7:0]          r_cnt;
    logic                r_out_valid;
    logic [NCH*OW-1:0]   r_out_data;
    logic [7:0]          r_out_cnt;

    logic [NCH*OW-1:0]   w_fold;
    logic [NCH*OW-1:0]   w_final;
    logic [7:0]          w_cnt_inc;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_acc_mode;

    // Fold every channel of the incoming beat into its output-width word.
    always_comb begin
        w_fold = '0;
        for (int c = 0; c < NCH; c++) begin
            w_fold[c*OW +: OW] = fold_word(bus.in_data[c*DW +: DW]);
        end
    end

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    // Once a packet is open, it finishes in accumulate mode whatever mode says.
    assign w_acc_mode = (r_state == ST_ACCUM) || bus.mode;
    assign w_cnt_inc  = (r_cnt == 8'd255) ? 8'd255 : (r_cnt + 8'd1);
    assign w_final    = r_acc ^ w_fold;

    // Packet FSM, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= 8'd0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (!w_acc_mode) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_fold;
                    r_out_cnt   <= 8'd1;
                end else if (bus.in_last) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_final;
                    r_out_cnt   <= w_cnt_inc;
                    r_acc       <= '0;
                    r_cnt       <= 8'd0;
                    r_state     <= ST_IDLE;
                end else begin
                    r_acc       <= w_final;
                    r_cnt       <= w_cnt_inc;
                    r_state     <= ST_ACCUM;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_cnt   = r_out_cnt;

`ifdef XOR_FOLD_PARITY_EN
    logic [NCH-1:0] r_out_par;
    logic [NCH-1:0] w_par_next;
    logic           w_load;

    assign w_load = w_accept && (!w_acc_mode || bus.in_last);

    // Parity of each channel of the value about to be loaded.
    always_comb begin
        w_par_next = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_acc_mode) begin
                w_par_next[c] = parity_word(w_final[c*OW +: OW]);
            end else begin
                w_par_next[c] = parity_word(w_fold[c*OW +: OW]);
            end
        end
    end

    // Parity register loads in lockstep with the output data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_par <= '0;
        end else if (w_load) begin
            r_out_par <= w_par_next;
        end
    end

    assign bus.out_par = r_out_par;
`endif
endmodule

// File: tb/tb_xor_fold_pipe.sv
// Directed self-checking bench for xor_fold_pipe (DW=32, FOLD=2, NCH=2).
module tb_xor_fold_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    int   pulses;
    logic [63:0] cap_data;
    logic [7:0]  cap_cnt;

    xor_fold_pipe_if #(.DW(32), .FOLD(2), .NCH(2)) bus ();

    xor_fold_pipe #(.DW(32), .FOLD(2), .NCH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = 64'h0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_out_data", bus.out_data[31:0], 64'h0);
        check("rst_out_cnt", {56'h0, bus.out_cnt}, 64'h0);
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        tick;
        tick;
        rst_n = 1'b1;

        // Mode 0 single beat
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h12345678_FFFF0000;
        tick;
        bus.in_valid = 1'b0;
        check("m0_valid", {63'h0, bus.out_valid}, 64'h1);
        check("m0_data", {32'h0, bus.out_data}, 64'h444CFFFF);
        check("m0_cnt", {56'h0, bus.out_cnt}, 64'h1);
        tick;
        check("m0_drop", {63'h0, bus.out_valid}, 64'h0);

        // Mode 1 three-beat packet; mode flips mid-packet but must be ignored
        bus.in_valid = 1'b1;
        bus.mode     = 1'b1;
        bus.in_data  = 64'h00000000_00000001;
        tick;
        check("m1_b1_novalid", {63'h0, bus.out_valid}, 64'h0);
        bus.mode     = 1'b0;
        bus.in_data  = 64'h00000000_00000002;
        tick;
        check("m1_b2_novalid", {63'h0, bus.out_valid}, 64'h0);
        bus.in_data  = 64'h00000000_00000004;
        bus.in_last  = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("m1_valid", {63'h0, bus.out_valid}, 64'h1);
        check("m1_data", {32'h0, bus.out_data}, 64'h00000007);
        check("m1_cnt", {56'h0, bus.out_cnt}, 64'h3);
        tick;
        check("m1_drop", {63'h0, bus.out_valid}, 64'h0);

        // Backpressure then four back-to-back beats
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h00000000_AAAA5555;
        tick;
        bus.in_data   = 64'h00000000_00010000;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {63'h0, bus.in_ready}, 64'h0);
            check("bp_valid", {63'h0, bus.out_valid}, 64'h1);
            check("bp_data", {32'h0, bus.out_data}, 64'h0000FFFF);
            check("bp_cnt", {56'h0, bus.out_cnt}, 64'h1);
            tick;
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'h0, bus.in_ready}, 64'h1);
        for (int i = 1; i <= 4; i++) begin
            tick;
            check("b2b_valid", {63'h0, bus.out_valid}, 64'h1);
            check("b2b_data", {32'h0, bus.out_data}, 64'(i));
            bus.in_data = {32'h0, 16'(i + 1), 16'h0};
            if (i == 4) bus.in_valid = 1'b0;
        end
        tick;
        check("b2b_drop", {63'h0, bus.out_valid}, 64'h0);

        // Reset in the middle of a packet discards the partial accumulation
        bus.mode     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h00000000_00000010;
        tick;
        bus.in_data  = 64'h00000000_00000020;
        tick;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("mid_rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check("mid_rst_cnt", {56'h0, bus.out_cnt}, 64'h0);
        tick;
        rst_n        = 1'b1;
        bus.mode     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = 64'h00000000_00000003;
        tick;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("post_rst_valid", {63'h0, bus.out_valid}, 64'h1);
        check("post_rst_data", {32'h0, bus.out_data}, 64'h00000003);
        check("post_rst_cnt", {56'h0, bus.out_cnt}, 64'h1);
        tick;

        // 300-beat packet saturates the count at 255
        pulses       = 0;
        cap_data     = 64'h0;
        cap_cnt      = 8'd0;
        bus.mode     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h00000000_00000001;
        for (int i = 0; i < 300; i++) begin
            bus.in_last = (i == 299);
            tick;
            if (bus.out_valid) begin
                pulses++;
                cap_data = {32'h0, bus.out_data};
                cap_cnt  = bus.out_cnt;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick;
        if (bus.out_valid) pulses++;
        check("sat_pulses", 64'(pulses), 64'h1);
        check("sat_cnt", {56'h0, cap_cnt}, 64'hFF);
        check("sat_data", cap_data, 64'h0);

`ifdef XOR_FOLD_PARITY_EN
        // Per-channel parity of the folded output
        bus.mode     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h00000000_00000007;
        tick;
        bus.in_valid = 1'b0;
        check("par_data", {32'h0, bus.out_data}, 64'h00000007);
        check("par_bits", {62'h0, bus.out_par}, 64'h1);
        tick;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/xor_fold_pipe.md
XOR_FOLD_PIPE -- requirements
Module: xor_fold_pipe

Interface
REQ-001 Parameter DW, default 32: per-channel input word width; SHALL be a multiple of FOLD.
REQ-002 Parameter FOLD, default 2: fold factor, >=2; output word width OW = DW/FOLD.
REQ-003 Parameter NCH, default 2: channel count, >=1; all channels share one handshake.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = per-beat fold; 1 = accumulate folds over a packet.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-009 in_last  input  1  last beat of packet; meaningful in mode 1 only.
REQ-010 in_data  input  NCH*DW  channel c occupies bits [c*DW +: DW].
REQ-011 out_valid  output  1  output beat present.
REQ-012 out_ready  input  1  output beat consumed when out_valid && out_ready.
REQ-013 out_data  output  NCH*OW  channel c occupies bits [c*OW +: OW].
REQ-014 out_cnt  output  8  beats folded into the current output, saturating.

Function
REQ-015 Fold: f_c[j] SHALL equal XOR over k=0..FOLD-1 of in_data[c*DW + k*OW + j], for j=0..OW-1.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational, no dependence on in_valid).
REQ-017 Mode 0: each accepted beat SHALL load out_data=f, out_cnt=1, out_valid=1 on the next edge (latency 1 cycle); in_last ignored.
REQ-018 Mode 1: accepted non-last beat SHALL update acc <= acc ^ f and cnt <= sat(cnt+1), producing no output.
REQ-019 Mode 1: accepted in_last beat SHALL load out_data=acc^f, out_cnt=sat(cnt+1), out_valid=1, and clear acc=0, cnt=0.
REQ-020 FSM states: IDLE (acc empty) and ACCUM (>=1 non-last beat absorbed); IDLE->ACCUM on accepted non-last beat in mode 1; ACCUM->IDLE on accepted in_last beat.
REQ-021 mode SHALL be sampled only on beats accepted in IDLE; in ACCUM the packet completes in mode 1 regardless of mode.
REQ-022 Single-beat packet (in_last on first beat, mode 1): out_data=f, out_cnt=1.
REQ-023 Saturation: cnt and out_cnt SHALL stop at 255 and never wrap.
REQ-024 While out_valid && !out_ready, out_data, out_cnt, and out_valid SHALL hold stable.
REQ-025 Out register consumed with no new output-producing beat in the same cycle: out_valid SHALL drop to 0 on the next edge.
REQ-026 Simultaneous consume and output-producing accept: out register SHALL reload in that cycle, giving sustained 1 beat/cycle throughput.

Reset
REQ-027 rst_n low SHALL immediately force out_valid=0, out_data=0, out_cnt=0, acc=0, cnt=0, state IDLE; any partial packet is discarded.
REQ-028 The first rising edge with rst_n high SHALL accept beats normally; in_ready=1 whenever out_valid=0.

Configuration
REQ-029 Macro XOR_FOLD_PARITY_EN defined: extra output port out_par [NCH], registered with out_data; bit c = XOR reduction of out_data channel c; reset 0; held stable under REQ-024.
REQ-030 Macro XOR_FOLD_PARITY_EN undefined: out_par port and its logic SHALL be absent; all other behaviour identical.

Verification (DW=32, FOLD=2, NCH=2)
REQ-031 Mode 0, ch0=0xFFFF0000, ch1=0x12345678, out_ready=1 -> one cycle later out_valid=1, ch0=0xFFFF, ch1=0x444C, out_cnt=1.
REQ-032 Mode 1, ch0 beats 0x00000001, 0x00000002, 0x00000004(last) -> single out_valid pulse, ch0=0x0007, out_cnt=3.
REQ-033 out_ready=0 for 5 cycles with out_valid=1 -> in_ready=0, outputs stable; then out_ready=1 with 4 back-to-back beats -> all accepted in 4 consecutive cycles.
REQ-034 Mode 1, reset after 2 non-last beats, then single beat ch0=0x00000003 last -> ch0=0x0003, out_cnt=1.
REQ-035 Mode 1, 300-beat packet -> out_cnt=255 exactly once.
REQ-036 XOR_FOLD_PARITY_EN defined, mode 0, ch0=0x00000007, ch1=0 -> out_par=2'b01.
